// File: rtl/fop_gen.sv
// fop_gen: walks indices 0..15 (order set by DIR) and emits members of the selected set over a ready/valid handshake.
// Optional macro FOP_GEN_STALL_CNT_EN adds an 8-bit stall_cnt output counting back-pressured cycles.
module fop_gen #(
  parameter int DIR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       ready,
  output logic [3:0] out,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [4:0] count
`ifdef FOP_GEN_STALL_CNT_EN
  ,
  output logic [7:0] stall_cnt
`endif
);

  // Bit n set when n belongs to the set: Fib {0,1,2,3,5,8,13}, prime {2,3,5,7,11,13}.
  localparam logic [15:0] FIB_MASK   = 16'h212F;
  localparam logic [15:0] PRIME_MASK = 16'h28AC;
  localparam logic [3:0]  FIRST_IDX  = (DIR == 0) ? 4'd0 : 4'd15;
  localparam logic [3:0]  LAST_IDX   = (DIR == 0) ? 4'd15 : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  index_reg, index_next;
  logic [1:0]  mode_reg, mode_next;
  logic [3:0]  out_reg, out_next;
  logic        valid_reg, valid_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [4:0]  count_reg, count_next;

  logic [15:0] member_vec;
  logic        member;
  logic        last;
  logic        accept;
  logic [3:0]  index_adv;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_member
      assign member_vec[gi] =
        (mode_reg == 2'b00) ? (FIB_MASK[gi] | PRIME_MASK[gi]) :
        (mode_reg == 2'b01) ?  FIB_MASK[gi] :
        (mode_reg == 2'b10) ?  PRIME_MASK[gi] :
                              ~(FIB_MASK[gi] | PRIME_MASK[gi]);
    end
  endgenerate

  assign member    = member_vec[index_reg];
  assign last      = (index_reg == LAST_IDX);
  assign accept    = valid_reg & ready;
  assign index_adv = (DIR == 0) ? (index_reg + 4'd1) : (index_reg - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = SCAN;
      SCAN: begin
        if (member)    state_next = EMIT;
        else if (last) state_next = DONE;
      end
      EMIT: begin
        if (accept) state_next = last ? DONE : SCAN;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of every registered output; busy/done follow the next state so they line up with it.
  always_comb begin
    index_next = index_reg;
    mode_next  = mode_reg;
    out_next   = out_reg;
    valid_next = valid_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next  = mode;
          index_next = FIRST_IDX;
          count_next = 5'd0;
        end
      end
      SCAN: begin
        if (member) begin
          out_next   = index_reg;
          valid_next = 1'b1;
        end else if (!last) begin
          index_next = index_adv;
        end
      end
      EMIT: begin
        if (accept) begin
          count_next = count_reg + 5'd1;
          valid_next = 1'b0;
          if (!last) index_next = index_adv;
        end
      end
      default: ;
    endcase
    busy_next = (state_next == SCAN) || (state_next == EMIT);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_reg <= 4'd0;
      mode_reg  <= 2'b00;
      out_reg   <= 4'd0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      count_reg <= 5'd0;
    end else begin
      index_reg <= index_next;
      mode_reg  <= mode_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      count_reg <= count_next;
    end
  end

  assign out   = out_reg;
  assign valid = valid_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign count = count_reg;

`ifdef FOP_GEN_STALL_CNT_EN
  logic [7:0] stall_reg, stall_next;

  always_comb begin
    stall_next = stall_reg;
    if ((state_reg == IDLE) && start) begin
      stall_next = 8'd0;
    end else if (valid_reg && !ready && (stall_reg != 8'hFF)) begin
      stall_next = stall_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_reg <= 8'd0;
    end else begin
      stall_reg <= stall_next;
    end
  end

  assign stall_cnt = stall_reg;
`endif

endmodule

// File: doc/fop_gen.md
FOP_GEN -- requirements
Module: fop_gen

Interface
REQ-001 SHALL have parameter DIR, default 0, meaning scan order: 0 ascending 0->15, 1 descending 15->0.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  begin one sequence; sampled only in IDLE.
REQ-005 SHALL have port mode  input  2  set select: 00 Fib-or-prime, 01 Fib only, 10 prime only, 11 neither; latched on accepted start.
REQ-006 SHALL have port ready  input  1  consumer accepts out when valid=1.
REQ-007 SHALL have port out  output  4  emitted value.
REQ-008 SHALL have port valid  output  1  out holds a member of the selected set.
REQ-009 SHALL have port busy  output  1  high in SCAN or EMIT.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sequence end.
REQ-011 SHALL have port count  output  5  members accepted this sequence, 0..16.

Function
REQ-012 SHALL define sets over 0..15: Fib={0,1,2,3,5,8,13}; prime={2,3,5,7,11,13}; Fib-or-prime={0,1,2,3,5,7,8,11,13}; neither={4,6,9,10,12,14,15}.
REQ-013 SHALL implement FSM states IDLE, SCAN, EMIT, DONE; all outputs registered.
REQ-014 IDLE: start=1 -> latch mode, index=0 (DIR=0) or 15 (DIR=1), count=0, go SCAN; start=0 -> stay.
REQ-015 SCAN: one index tested per cycle; member -> out<=index, valid<=1, go EMIT; non-member and last index -> go DONE; non-member otherwise -> advance index, stay SCAN.
REQ-016 EMIT: out and valid SHALL stay stable until valid&&ready; no change to out while stalled.
REQ-017 EMIT, valid&&ready: count+1, valid<=0; last index -> DONE, else advance index, go SCAN.
REQ-018 DONE: done=1 for exactly one cycle, count held, go IDLE; count retains final value until next accepted start.
REQ-019 Latency: member at first index -> valid high 2 cycles after start sampled; each non-member index adds 1 cycle; after handshake, next member at adjacent index -> valid after 2 cycles.
REQ-020 start while busy or in DONE SHALL be ignored; mode changes after latch SHALL be ignored.
REQ-021 Index SHALL not wrap: last index (15 for DIR=0, 0 for DIR=1) ends sequence; no value emitted twice per sequence.
REQ-022 ready while valid=0 SHALL have no effect; ready held high -> back-to-back handshakes, no dropped values.
REQ-023 busy=1 exactly in SCAN and EMIT.

Reset
REQ-024 rst=1 at rising edge SHALL force IDLE, out=0, valid=0, busy=0, done=0, count=0, index=0, latched mode=00, regardless of state.
REQ-025 Reset mid-sequence SHALL abandon it without a done pulse; first start after rst deassertion begins a fresh sequence.

Configuration
REQ-026 Macro FOP_GEN_STALL_CNT_EN defined: extra output stall_cnt (8 bits) counts cycles with valid=1 and ready=0, saturates at 255, cleared by rst and accepted start.
REQ-027 Macro FOP_GEN_STALL_CNT_EN undefined: stall_cnt port and logic absent; all other behaviour identical.

Verification
REQ-028 DIR=0, mode=00, ready=1, start pulse -> out sequence 0,1,2,3,5,7,8,11,13, one done pulse, count=9.
REQ-029 DIR=1, mode=10, ready=1 -> out 13,11,7,5,3,2; count=6; mode=11 same DIR -> 15,14,12,10,9,6,4, count=7.
REQ-030 mode=01, ready low 5 cycles on first valid -> out=0 held stable 5 cycles, then 0,1,2,3,5,8,13, count=7; with macro stall_cnt=5.
REQ-031 rst asserted while EMIT on out=5 -> next cycle valid=0, busy=0, count=0, no done pulse; restart yields full sequence.
REQ-032 start pulsed and mode toggled during SCAN/EMIT -> sequence unaffected, single done pulse; start held high through DONE -> new sequence begins from IDLE.
